// File: rtl/pll_reset_sequencer.sv
// System reset sequencer for the PLL clock domain: power-on stretch plus debounced pushbutton hold.
// Optional macro PLL_RESET_COUNT_EN adds an 8-bit saturating count of button-initiated resets.
module pll_reset_sequencer #(
  parameter int STARTUP_CYCLES  = 1024,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_n,
  output logic       sys_reset,
  output logic       sys_resetn
`ifdef PLL_RESET_COUNT_EN
  ,
  output logic [7:0] reset_count
`endif
);

  localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(STARTUP_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_POR  = 2'd0,
    S_RUN  = 2'd1,
    S_HELD = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] scnt;
  logic [SW-1:0] scnt_next;
  logic [1:0]    sync;
  logic          btn_s;
  logic          btn_d;
  logic [DW-1:0] dcnt;

  assign btn_s = sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[0], button_n};
    end
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_d <= 1'b1;
      dcnt  <= '0;
    end else if (btn_s == btn_d) begin
      dcnt <= '0;
    end else if (dcnt == D_LAST) begin
      btn_d <= btn_s;
      dcnt  <= '0;
    end else begin
      dcnt <= dcnt + DW'(1);
    end
  end

  always_comb begin
    state_next = state;
    scnt_next  = scnt;
    case (state)
      S_POR: begin
        if (!btn_d) begin
          state_next = S_HELD;
          scnt_next  = '0;
        end else if (scnt == S_LAST) begin
          state_next = S_RUN;
          scnt_next  = '0;
        end else begin
          scnt_next = scnt + SW'(1);
        end
      end
      S_RUN: begin
        if (!btn_d) begin
          state_next = S_HELD;
        end
      end
      S_HELD: begin
        if (btn_d) begin
          state_next = S_POR;
          scnt_next  = '0;
        end
      end
      default: begin
        state_next = S_POR;
        scnt_next  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_POR;
      scnt       <= '0;
      sys_reset  <= 1'b1;
      sys_resetn <= 1'b0;
    end else begin
      state      <= state_next;
      scnt       <= scnt_next;
      sys_reset  <= (state_next != S_RUN);
      sys_resetn <= (state_next == S_RUN);
    end
  end

`ifdef PLL_RESET_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      reset_count <= '0;
    end else if (state == S_RUN && state_next == S_HELD && reset_count != '1) begin
      reset_count <= reset_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus random button activity
// compared every cycle against a phase-based reference model.
module tb_pll_reset_sequencer;

  localparam int ST  = 16;
  localparam int DEB = 8;

  localparam int P_POR  = 0;
  localparam int P_RUN  = 1;
  localparam int P_HELD = 2;

  logic clk;
  logic reset;
  logic button_n;
  logic sys_reset;
  logic sys_resetn;
`ifdef PLL_RESET_COUNT_EN
  logic [7:0] reset_count;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  logic m_s1, m_s2, m_d, m_exp;
  int   m_run, m_phase, m_stretch, m_count;

  pll_reset_sequencer #(
    .STARTUP_CYCLES (ST),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button_n  (button_n),
    .sys_reset (sys_reset),
    .sys_resetn(sys_resetn)
`ifdef PLL_RESET_COUNT_EN
    ,
    .reset_count(reset_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advances the model across one clock edge given the inputs held during that edge.
  function automatic void model_edge(input logic r, input logic b);
    if (r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_d = 1'b1; m_run = 0;
      m_phase = P_POR; m_stretch = 0; m_exp = 1'b1;
      m_count = 0;
      return;
    end
    case (m_phase)
      P_POR: begin
        if (!m_d) m_phase = P_HELD;
        else begin
          m_stretch++;
          if (m_stretch == ST) m_phase = P_RUN;
        end
      end
      P_RUN: begin
        if (!m_d) begin
          m_phase = P_HELD;
          if (m_count < 255) m_count++;
        end
      end
      default: begin
        if (m_d) begin
          m_phase = P_POR;
          m_stretch = 0;
        end
      end
    endcase
    m_exp = (m_phase != P_RUN);
    if (m_s2 != m_d) begin
      m_run++;
      if (m_run == DEB) begin
        m_d = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = b;
  endfunction

  task automatic tick(input logic r, input logic b);
    reset    = r;
    button_n = b;
    model_edge(r, b);
    @(negedge clk);
    chk("sys_reset", sys_reset, m_exp);
    chk("sys_resetn", sys_resetn, !m_exp);
`ifdef PLL_RESET_COUNT_EN
    chk("reset_count_model", reset_count, m_count);
`endif
  endtask

  // Ticks with reset low until sys_reset reaches target; n is edges taken, -1 on timeout.
  task automatic wait_level(input logic b, input logic target, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick(1'b0, b);
      if (sys_reset === target) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    button_n = 1'b1;

    // power-up stretch
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    chk("reset_state_sys_reset", sys_reset, 1);
    chk("reset_state_sys_resetn", sys_resetn, 0);
    wait_level(1'b1, 1'b0, 100, n);
    chk("powerup_fall_edge", n, ST);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    chk("powerup_steady", sys_reset, 0);

    // short glitches are rejected
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b1);
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
    chk("glitch_reject", sys_reset, 0);

    // clean press and release
    wait_level(1'b0, 1'b1, 40, n);
    chk("press_latency", n, 2 + DEB + 1);
    for (int i = n; i < 40; i++) tick(1'b0, 1'b0);
    chk("held_in_reset", sys_reset, 1);
    wait_level(1'b1, 1'b0, 80, n);
    chk("release_stretch", n, 2 + DEB + 1 + ST);

    // reset in the middle of the stretch restarts the count
    tick(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("midstretch_reset_out", sys_reset, 1);
    wait_level(1'b1, 1'b0, 100, n);
    chk("midstretch_fall_edge", n, ST);

    // button held through reset release
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
    chk("held_through_reset", sys_reset, 1);
    wait_level(1'b1, 1'b0, 100, n);
    chk("held_release_fall", n, 2 + DEB + 1 + ST);

`ifdef PLL_RESET_COUNT_EN
    tick(1'b1, 1'b1);
    chk("count_after_reset", reset_count, 0);
    wait_level(1'b1, 1'b0, 100, n);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
      wait_level(1'b1, 1'b0, 80, n);
    end
    chk("count_three", reset_count, 3);
    for (int p = 0; p < 300; p++) begin
      for (int i = 0; i < 13; i++) tick(1'b0, 1'b0);
      wait_level(1'b1, 1'b0, 80, n);
    end
    chk("count_saturate", reset_count, 255);
    tick(1'b1, 1'b1);
    chk("count_cleared", reset_count, 0);
`endif

    // random button activity with occasional resets
    tick(1'b1, 1'b1);
    for (int s = 0; s < 250; s++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 3 * DEB);
      if ($urandom_range(0, 39) == 0) tick(1'b1, lvl);
      for (int i = 0; i < len; i++) tick(1'b0, lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
